// File: rtl/inst_decode_stage_pkg.sv
// inst_decode_stage_pkg: opcode map, immediate-type codes, control bundle and the opcode decoder
package inst_decode_stage_pkg;
  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_type_e;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  typedef struct packed {
    imm_type_e  imm_type;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       reg_wen;
    logic       mem_rd;
    logic       mem_wr;
    logic       branch;
    logic       jump;
    logic       alu_src_b;
    logic       illegal;
  } ctrl_t;
  localparam ctrl_t CTRL_RST = '{IMM_NONE, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  function automatic ctrl_t decode(input logic [31:0] inst);
    ctrl_t c;
    c = CTRL_RST;
    c.rs1 = inst[19:15];
    c.rs2 = inst[24:20];
    c.rd  = inst[11:7];
    case (inst[6:0])
      OP_LUI, OP_AUIPC: begin c.imm_type = IMM_U; c.alu_src_b = 1'b1; c.reg_wen = 1'b1; end
      OP_JAL:           begin c.imm_type = IMM_J; c.alu_src_b = 1'b1; c.reg_wen = 1'b1; c.jump = 1'b1; end
      OP_JALR:          begin c.imm_type = IMM_I; c.alu_src_b = 1'b1; c.reg_wen = 1'b1; c.jump = 1'b1; end
      OP_BRANCH:        begin c.imm_type = IMM_B; c.branch = 1'b1; end
      OP_LOAD:          begin c.imm_type = IMM_I; c.alu_src_b = 1'b1; c.reg_wen = 1'b1; c.mem_rd = 1'b1; end
      OP_STORE:         begin c.imm_type = IMM_S; c.alu_src_b = 1'b1; c.mem_wr = 1'b1; end
      OP_IMM, OP_SYSTEM: begin c.imm_type = IMM_I; c.alu_src_b = 1'b1; c.reg_wen = 1'b1; end
      OP_OP:            c.reg_wen = 1'b1;
      default:          c.illegal = 1'b1;
    endcase
    // x0 is hardwired zero, so a write to it is never requested
    c.reg_wen = c.reg_wen & (inst[11:7] != 5'd0);
    return c;
  endfunction
endpackage

// File: rtl/inst_decode_stage_skid.sv
// inst_decode_stage_skid: skid entry in front of the ID/EX register, with registered in_ready
// Ports: in_valid/in_ready/in_data from fetch; out_valid/out_data present the word entering the
// output register, out_ready says that register advances this cycle; flush kills skid and input.
module inst_decode_stage_skid #(
  parameter int W       = 64,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid_q, skid_valid_d, rdy_q, rdy_d, accept;
  logic [W-1:0] skid_data_q, skid_data_d;
  always_comb begin
    accept       = in_valid & in_ready & !flush;
    skid_valid_d = !flush & (skid_valid_q ? !out_ready : (SKID_EN & accept & !out_ready));
    skid_data_d  = skid_valid_q ? skid_data_q : in_data;
    rdy_d        = !skid_valid_d;
  end
  // while the skid is full in_ready is low, so accept and skid drain never overlap
  assign in_ready  = SKID_EN ? rdy_q : out_ready;
  assign out_valid = skid_valid_q | accept;
  assign out_data  = skid_valid_q ? skid_data_q : in_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      rdy_q        <= 1'b1;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      rdy_q        <= rdy_d;
    end
  end
endmodule

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: RISC-V ID stage, decodes fetched words into the registered ID/EX boundary
// Ports: clk, rst (async high), flush; fetch side if_valid/if_ready/if_inst/if_pc;
// execute side ex_valid/ex_ready plus registered ex_inst, ex_pc and decoded control fields.
module inst_decode_stage
  import inst_decode_stage_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_inst,
  input  logic [XLEN-1:0] if_pc,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] ex_inst,
  output logic [XLEN-1:0] ex_pc,
  output logic [2:0]      ex_imm_type,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_wen,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr,
  output logic            ex_branch,
  output logic            ex_jump,
  output logic            ex_alu_src_b,
  output logic            ex_illegal
);
  logic              adv, fwd_valid, ld, ex_valid_q, ex_valid_d;
  logic [2*XLEN-1:0] fwd_data;
  logic [XLEN-1:0]   inst_q, inst_d, pc_q, pc_d;
  ctrl_t             ctrl_q, ctrl_d;
  assign adv = !ex_valid_q | ex_ready;
  inst_decode_stage_skid #(.W(2*XLEN), .SKID_EN(SKID_EN)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (if_valid),
    .in_ready  (if_ready),
    .in_data   ({if_pc, if_inst}),
    .out_valid (fwd_valid),
    .out_ready (adv),
    .out_data  (fwd_data)
  );
  // decode only the word being loaded; held fields are never re-decoded
  always_comb begin
    ld         = !flush & adv & fwd_valid;
    ex_valid_d = !flush & (adv ? fwd_valid : ex_valid_q);
    inst_d     = ld ? fwd_data[XLEN-1:0] : inst_q;
    pc_d       = ld ? fwd_data[2*XLEN-1:XLEN] : pc_q;
    ctrl_d     = ld ? decode(fwd_data[31:0]) : ctrl_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      inst_q     <= '0;
      pc_q       <= '0;
      ctrl_q     <= CTRL_RST;
    end else begin
      ex_valid_q <= ex_valid_d;
      inst_q     <= inst_d;
      pc_q       <= pc_d;
      ctrl_q     <= ctrl_d;
    end
  end
  assign ex_valid     = ex_valid_q;
  assign ex_inst      = inst_q;
  assign ex_pc        = pc_q;
  assign ex_imm_type  = ctrl_q.imm_type;
  assign ex_rs1       = ctrl_q.rs1;
  assign ex_rs2       = ctrl_q.rs2;
  assign ex_rd        = ctrl_q.rd;
  assign ex_reg_wen   = ctrl_q.reg_wen;
  assign ex_mem_rd    = ctrl_q.mem_rd;
  assign ex_mem_wr    = ctrl_q.mem_wr;
  assign ex_branch    = ctrl_q.branch;
  assign ex_jump      = ctrl_q.jump;
  assign ex_alu_src_b = ctrl_q.alu_src_b;
  assign ex_illegal   = ctrl_q.illegal;
endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: directed self-checking bench with an in-order inst/pc scoreboard
module tb_inst_decode_stage;
  logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic        if_valid = 1'b0, if_ready, ex_valid, ex_ready = 1'b0;
  logic [31:0] if_inst = '0, if_pc = '0, ex_inst, ex_pc;
  logic [2:0]  ex_imm_type;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic        ex_reg_wen, ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_alu_src_b, ex_illegal;
  int          checks = 0, errors = 0;
  logic [63:0] sb[$];
  logic [63:0] exp_beat;
  typedef struct {
    logic [31:0] inst;
    logic [2:0]  imm;
    logic        wen, mrd, mwr, br, jmp, ill;
  } dec_vec_t;
  dec_vec_t vecs[7];
  inst_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst), .if_pc(if_pc),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_imm_type(ex_imm_type), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_reg_wen(ex_reg_wen), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src_b(ex_alu_src_b), .ex_illegal(ex_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // one clock: scoreboard at the falling edge, return 1 time unit after the rising edge
  task automatic cyc();
    @(negedge clk);
    if (flush) sb.delete();
    else begin
      if (ex_valid && ex_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL sb_unexpected: observed inst %0h expected no output", ex_inst);
        end
        if (sb.size() != 0) begin
          exp_beat = sb.pop_front();
          chk("sb_order", {ex_pc, ex_inst}, exp_beat);
        end
      end
      if (if_valid && if_ready) sb.push_back({if_pc, if_inst});
    end
    @(posedge clk);
    #1;
  endtask
  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    if_valid = 1'b1;
    if_inst  = inst;
    if_pc    = pc;
    cyc();
  endtask
  initial begin
    vecs[0] = '{32'h00112023, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h00000463, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h123450B7, 3'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h008000EF, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h0000007F, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{32'h00000033, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'h00012103, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_imm_type", ex_imm_type, 7);
    chk("rst_if_ready", if_ready, 1);
    chk("rst_ex_inst", ex_inst, 0);
    cyc();
    chk("idle_ex_valid", ex_valid, 0);
    chk("idle_if_ready", if_ready, 1);
    ex_ready = 1'b1;
    offer(32'h00500093, 32'h100);
    if_valid = 1'b0;
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm_type, 0);
    chk("addi_rd", ex_rd, 1);
    chk("addi_wen", ex_reg_wen, 1);
    chk("addi_alu_src_b", ex_alu_src_b, 1);
    cyc();
    chk("addi_drained", ex_valid, 0);
    ex_ready = 1'b0;
    offer(32'h00100113, 32'h200);
    offer(32'h00200193, 32'h204);
    chk("bp_if_ready", if_ready, 0);
    chk("bp_hold_b1", ex_inst, 32'h00100113);
    offer(32'h00300213, 32'h208);
    chk("bp_still_b1", ex_inst, 32'h00100113);
    chk("bp_still_valid", ex_valid, 1);
    chk("bp_still_blocked", if_ready, 0);
    ex_ready = 1'b1;
    cyc();
    chk("bp_b2_out", ex_inst, 32'h00200193);
    cyc();
    chk("bp_b3_out", ex_inst, 32'h00300213);
    if_valid = 1'b0;
    cyc();
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_drained", ex_valid, 0);
    ex_ready = 1'b0;
    offer(32'h00400293, 32'h300);
    offer(32'h00500313, 32'h304);
    chk("fl_full", if_ready, 0);
    flush = 1'b1;
    offer(32'h00600393, 32'h308);
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fl_ex_valid", ex_valid, 0);
    chk("fl_if_ready", if_ready, 1);
    ex_ready = 1'b1;
    flush = 1'b1;
    offer(32'h00700413, 32'h30c);
    flush = 1'b0;
    if_valid = 1'b0;
    chk("fl_drop_open", ex_valid, 0);
    repeat (3) cyc();
    chk("fl_nothing_out", ex_valid, 0);
    foreach (vecs[i]) begin
      offer(vecs[i].inst, 32'h400 + 32'(i) * 4);
      if_valid = 1'b0;
      chk($sformatf("dec%0d_imm", i), ex_imm_type, vecs[i].imm);
      chk($sformatf("dec%0d_wen", i), ex_reg_wen, vecs[i].wen);
      chk($sformatf("dec%0d_ctl", i), {ex_mem_rd, ex_mem_wr, ex_branch, ex_jump, ex_illegal},
          {vecs[i].mrd, vecs[i].mwr, vecs[i].br, vecs[i].jmp, vecs[i].ill});
      cyc();
    end
    chk("dec_sb_empty", sb.size(), 0);
    ex_ready = 1'b0;
    offer(32'h00800493, 32'h500);
    offer(32'h00900513, 32'h504);
    if_valid = 1'b0;
    chk("ar_pre_valid", ex_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_ex_valid", ex_valid, 0);
    chk("ar_if_ready", if_ready, 1);
    chk("ar_imm_type", ex_imm_type, 7);
    chk("ar_ex_inst", ex_inst, 0);
    sb.delete();
    cyc();
    rst = 1'b0;
    cyc();
    chk("ar_idle", ex_valid, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
